// File: rtl/pipelined_rca_adder_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
package pipelined_rca_adder_pkg;

    // Default build: 16-bit operands split into four 4-bit ripple segments.
    localparam int unsigned DEF_BIT_WIDTH = 16;
    localparam int unsigned DEF_STAGES    = 4;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/pipelined_rca_adder_rca_segment.sv
// Combinational W-bit ripple-carry adder used as one pipeline segment.
module rca_segment #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    // Bit-serial carry chain kept in a function so the carry is a local variable.
    function automatic logic [W:0] ripple(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic         cin
    );
        logic         c;
        logic [W-1:0] r;
        c = cin;
        r = '0;
        for (int unsigned i = 0; i < W; i++) begin
            r[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, r};
    endfunction

    // Sum and carry out of the segment.
    always_comb begin
        {co, s} = ripple(a, b, ci);
    end

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined add/subtract: STAGES ripple segments with registered carries,
// skewed operand capture, deskewed results and a valid/ready handshake.
module pipelined_rca_adder
    import pipelined_rca_adder_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int unsigned STAGES    = DEF_STAGES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] add_1,
    input  logic [BIT_WIDTH-1:0] add_2,
    input  logic                 c_in,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 c_out,
    output logic                 ovf
);

    localparam int unsigned SEG = BIT_WIDTH / STAGES;

    // Rank k holds the operation k cycles after capture; rank STAGES is the output.
    logic                 w_adv;
    logic [STAGES:0]      w_ld;
    logic [STAGES:0]      r_v;
    logic [STAGES:0]      r_c;
    logic [STAGES-1:0]    w_co;
    logic [BIT_WIDTH-1:0] w_sq;
    logic                 w_a_msb;
    logic                 w_b_msb;
    logic                 w_s_msb;
    logic                 r_ovf;

    // Whole pipeline moves only when the output slot is free or being drained.
    assign w_adv    = !r_v[STAGES] || out_ready;
    assign in_ready = w_adv;

    // Per-rank load enables: advance and a valid operation arriving at that rank.
    always_comb begin
        w_ld    = '0;
        w_ld[0] = w_adv && in_valid;
        for (int unsigned k = 1; k <= STAGES; k++) begin
            w_ld[k] = w_adv && r_v[k-1];
        end
    end

    // Valid bits shift with the pipeline so bubbles stay in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
        end else if (w_adv) begin
            r_v <= {r_v[STAGES-1:0], in_valid};
        end
    end

    // Carry chain between segments; subtract forces the initial carry to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c <= '0;
        end else begin
            if (w_ld[0]) begin
                r_c[0] <= sub | c_in;
            end
            for (int unsigned k = 1; k <= STAGES; k++) begin
                if (w_ld[k]) begin
                    r_c[k] <= w_co[k-1];
                end
            end
        end
    end

    // Overflow computed as the top segment completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_ld[STAGES]) begin
            r_ovf <= signed_ovf(w_a_msb, w_b_msb, w_s_msb);
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_seg
        localparam int unsigned IDLY = j;
        localparam int unsigned ODLY = STAGES - 1 - j;

        logic [SEG-1:0] r_a_d [0:IDLY];
        logic [SEG-1:0] r_b_d [0:IDLY];
        logic [SEG-1:0] r_s_d [0:ODLY];
        logic [SEG-1:0] w_s;

        rca_segment #(
            .W (SEG)
        ) u_rca (
            .a  (r_a_d[IDLY]),
            .b  (r_b_d[IDLY]),
            .ci (r_c[j]),
            .s  (w_s),
            .co (w_co[j])
        );

        // Operand skew: segment j waits j cycles for its incoming carry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned m = 0; m <= IDLY; m++) begin
                    r_a_d[m] <= '0;
                    r_b_d[m] <= '0;
                end
            end else begin
                if (w_ld[0]) begin
                    r_a_d[0] <= add_1[j*SEG +: SEG];
                    r_b_d[0] <= add_2[j*SEG +: SEG] ^ {SEG{sub}};
                end
                for (int unsigned m = 1; m <= IDLY; m++) begin
                    if (w_ld[m]) begin
                        r_a_d[m] <= r_a_d[m-1];
                        r_b_d[m] <= r_b_d[m-1];
                    end
                end
            end
        end

        // Result deskew: finished segment j waits for the segments above it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned m = 0; m <= ODLY; m++) begin
                    r_s_d[m] <= '0;
                end
            end else begin
                if (w_ld[j+1]) begin
                    r_s_d[0] <= w_s;
                end
                for (int unsigned m = 1; m <= ODLY; m++) begin
                    if (w_ld[j+1+m]) begin
                        r_s_d[m] <= r_s_d[m-1];
                    end
                end
            end
        end

        assign w_sq[j*SEG +: SEG] = r_s_d[ODLY];

        // Sign bits for overflow come from the top segment's delayed operands.
        if (j == STAGES - 1) begin : g_top
            assign w_a_msb = r_a_d[IDLY][SEG-1];
            assign w_b_msb = r_b_d[IDLY][SEG-1];
            assign w_s_msb = w_s[SEG-1];
        end
    end

    assign sum       = w_sq;
    assign c_out     = r_c[STAGES];
    assign ovf       = r_ovf;
    assign out_valid = r_v[STAGES];

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed bench for pipelined_rca_adder (16-bit, 4 stages).
module tb_pipelined_rca_adder;

    localparam int unsigned W  = 16;
    localparam int unsigned ST = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] add_1;
    logic [W-1:0] add_2;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int idx;

    // Stream table: slot 4 is a bubble.
    logic [15:0] s_a   [0:8] = '{16'hA5A5, 16'hA5A5, 16'h8000, 16'h1111, 16'h0000,
                                 16'h0F0F, 16'h4000, 16'h0000, 16'hC000};
    logic [15:0] s_b   [0:8] = '{16'h5A5A, 16'h5A5A, 16'h8000, 16'h2222, 16'h0000,
                                 16'h00F1, 16'h4000, 16'h0000, 16'h4001};
    logic        s_ci  [0:8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        s_sub [0:8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        s_v   [0:8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] s_es  [0:8] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hEEEF, 16'h0000,
                                 16'h1000, 16'h8000, 16'h0000, 16'h7FFF};
    logic        s_eco [0:8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        s_eov [0:8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Stall/reset table.
    logic [15:0] t_a   [0:5] = '{16'h0001, 16'h00FF, 16'h0FFF, 16'hFFF0, 16'h1000, 16'h3333};
    logic [15:0] t_b   [0:5] = '{16'h0002, 16'h0001, 16'h0001, 16'h0020, 16'h0001, 16'h4444};
    logic        t_sub [0:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] t_es  [0:5] = '{16'h0003, 16'h0100, 16'h1000, 16'h0010, 16'h0FFF, 16'h7777};
    logic        t_eco [0:5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    pipelined_rca_adder #(
        .BIT_WIDTH (W),
        .STAGES    (ST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .add_1     (add_1),
        .add_2     (add_2),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic s, input logic v);
        add_1    = a;
        add_2    = b;
        c_in     = ci;
        sub      = s;
        in_valid = v;
    endtask

    // One isolated operation: checks latency, result and single-cycle out_valid.
    task automatic run_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic ci, input logic s, input logic [15:0] es,
                              input logic eco, input logic eov);
        drive(a, b, ci, s, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < int'(ST); i++) begin
            chk({tag, "_early"}, 32'(out_valid), 32'(0));
            @(negedge clk);
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'(1));
        chk({tag, "_sum"},   32'(sum),       32'(es));
        chk({tag, "_cout"},  32'(c_out),     32'(eco));
        chk({tag, "_ovf"},   32'(ovf),       32'(eov));
        @(negedge clk);
        chk({tag, "_once"},  32'(out_valid), 32'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready",  32'(in_ready),  32'(1));
        chk("rst_sum",       32'(sum),       32'(0));
        chk("rst_cout",      32'(c_out),     32'(0));
        chk("rst_ovf",       32'(ovf),       32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Isolated operations
        run_single("add_basic",  16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
        run_single("add_carry",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_single("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_single("sub_neg",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_single("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_single("sub_pos",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);

        // Back-to-back stream with one bubble
        for (int k = 0; k < 9 + int'(ST) + 2; k++) begin
            if (k >= int'(ST) + 1 && k - int'(ST) - 1 < 9) begin
                int t;
                t = k - int'(ST) - 1;
                chk("stream_valid", 32'(out_valid), 32'(s_v[t]));
                if (s_v[t]) begin
                    chk("stream_sum",  32'(sum),   32'(s_es[t]));
                    chk("stream_cout", 32'(c_out), 32'(s_eco[t]));
                    chk("stream_ovf",  32'(ovf),   32'(s_eov[t]));
                end
            end
            if (k < 9) drive(s_a[k], s_b[k], s_ci[k], s_sub[k], s_v[k]);
            else       in_valid = 1'b0;
            @(negedge clk);
        end

        // Fill the pipeline, then stall the output for three cycles
        for (int i = 0; i < 5; i++) begin
            drive(t_a[i], t_b[i], 1'b0, t_sub[i], 1'b1);
            @(negedge clk);
        end
        chk("stall_head_valid", 32'(out_valid), 32'(1));
        chk("stall_head_sum",   32'(sum),       32'(t_es[0]));
        out_ready = 1'b0;
        drive(t_a[5], t_b[5], 1'b0, t_sub[5], 1'b1);
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold_valid", 32'(out_valid), 32'(1));
            chk("stall_hold_sum",   32'(sum),       32'(t_es[0]));
            chk("stall_hold_ready", 32'(in_ready),  32'(0));
        end
        out_ready = 1'b1;
        #1;
        chk("stall_release_ready", 32'(in_ready), 32'(1));
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) begin
                if (idx < 6) begin
                    chk("stall_drain_sum",  32'(sum),   32'(t_es[idx]));
                    chk("stall_drain_cout", 32'(c_out), 32'(t_eco[idx]));
                end
                idx++;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("stall_result_count", 32'(idx), 32'(6));

        // Reset with operations in flight
        for (int i = 0; i < 5; i++) begin
            drive(t_a[i], t_b[i], 1'b0, t_sub[i], 1'b1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mid_rst_pre_valid", 32'(out_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(out_valid), 32'(0));
        chk("mid_rst_sum",      32'(sum),       32'(0));
        chk("mid_rst_cout",     32'(c_out),     32'(0));
        chk("mid_rst_in_ready", 32'(in_ready),  32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 32'(out_valid), 32'(0));
        end

        // Pipeline is usable again after reset
        run_single("post_rst_add", 16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
